// File: rtl/dtw_cost_engine_if.sv
// Bus between the DTW address generator and the cost engine.
// master: address generator (drives state code, cell_start, samples, row-buffer read data)
// slave : cost engine (drives write strobes, cost, status and final result)
interface dtw_cost_engine_if #(
    parameter int DW = 32
) ();
    logic [3:0]    dtw_state;
    logic          cell_start;
    logic [DW-1:0] temp_data;
    logic [DW-1:0] test_data;
    logic [DW-1:0] even_douta;
    logic [DW-1:0] even_doutb;
    logic [DW-1:0] odd_douta;
    logic [DW-1:0] odd_doutb;
    logic          even_we;
    logic          odd_we;
    logic [DW-1:0] cost_wdata;
    logic          busy;
    logic          cell_done;
    logic          err_overrun;
    logic [DW-1:0] dtw_distance;
    logic          result_valid;

    modport master (
        output dtw_state, cell_start, temp_data, test_data,
               even_douta, even_doutb, odd_douta, odd_doutb,
        input  even_we, odd_we, cost_wdata, busy, cell_done,
               err_overrun, dtw_distance, result_valid
    );

    modport slave (
        input  dtw_state, cell_start, temp_data, test_data,
               even_douta, even_doutb, odd_douta, odd_doutb,
        output even_we, odd_we, cost_wdata, busy, cell_done,
               err_overrun, dtw_distance, result_valid
    );
endinterface

// File: rtl/dtw_cost_engine.sv
// DTW cell cost engine: for each cell computes the L1 feature distance between
// a template and a test sample, adds the minimum of the available neighbour
// costs (up / diag / left) and writes the saturated result into the even or
// odd row buffer. Latches the last written cost as the final DTW distance.
// Ports: clk, rst (synchronous, active-high), bus (dtw_cost_engine_if.slave).
//
// state | meaning
// IDLE  | waiting for a valid cell_start; latches final result on dtw_state 9
// LOAD  | samples/operands captured on entry; feature distance computed
// DIST  | minimum of present neighbour operands computed
// MIN   | saturated cost computed, strobes/cell_done set for the next cycle
// WRITE | strobe and cell_done visible; returns to IDLE
module dtw_cost_engine #(
    parameter int DW = 32
) (
    input logic              clk,
    input logic              rst,
    dtw_cost_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, DIST, MIN, WRITE} fsm_t;

    fsm_t          fsm;
    logic [31:0]   temp_r;
    logic [31:0]   test_r;
    logic [3:0]    st_r;
    logic [DW-1:0] up_r;
    logic [DW-1:0] diag_r;
    logic [DW-1:0] left_r;
    logic [DW-1:0] m_r;
    logic          has_up;
    logic          has_diag;
    logic          has_left;
    logic [17:0]   d_r;
    logic          fin_seen;

    logic          even_we_r;
    logic          odd_we_r;
    logic [DW-1:0] cost_r;
    logic          busy_r;
    logic          cell_done_r;
    logic          err_r;
    logic [DW-1:0] dist_r;
    logic          valid_r;

    function automatic logic [16:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] x;
        x = $signed({a[15], a}) - $signed({b[15], b});
        return x[16] ? $unsigned(-x) : $unsigned(x);
    endfunction

    logic [17:0]   d_c;
    logic [DW-1:0] m_c;
    logic          m_found;
    logic [DW:0]   sum_c;
    logic [DW-1:0] cost_c;
    logic          cell_ok;

    assign d_c = {1'b0, abs_diff(temp_r[15:0], test_r[15:0])}
               + {1'b0, abs_diff(temp_r[31:16], test_r[31:16])};

    // Absent operands never take part; with none present the minimum is 0.
    always_comb begin
        m_c     = '0;
        m_found = 1'b0;
        if (has_up) begin
            m_c     = up_r;
            m_found = 1'b1;
        end
        if (has_diag && (!m_found || diag_r < m_c)) begin
            m_c     = diag_r;
            m_found = 1'b1;
        end
        if (has_left && (!m_found || left_r < m_c)) begin
            m_c = left_r;
        end
    end

    assign sum_c   = {1'b0, m_r} + {{(DW-17){1'b0}}, d_r};
    assign cost_c  = sum_c[DW] ? {DW{1'b1}} : sum_c[DW-1:0];
    assign cell_ok = (bus.dtw_state >= 4'd3) && (bus.dtw_state <= 4'd8);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            temp_r      <= '0;
            test_r      <= '0;
            st_r        <= '0;
            up_r        <= '0;
            diag_r      <= '0;
            left_r      <= '0;
            m_r         <= '0;
            has_up      <= 1'b0;
            has_diag    <= 1'b0;
            has_left    <= 1'b0;
            d_r         <= '0;
            fin_seen    <= 1'b0;
            even_we_r   <= 1'b0;
            odd_we_r    <= 1'b0;
            cost_r      <= '0;
            busy_r      <= 1'b0;
            cell_done_r <= 1'b0;
            err_r       <= 1'b0;
            dist_r      <= '0;
            valid_r     <= 1'b0;
        end else begin
            even_we_r   <= 1'b0;
            odd_we_r    <= 1'b0;
            cell_done_r <= 1'b0;

            if (bus.dtw_state == 4'd0) begin
                valid_r <= 1'b0;
                err_r   <= 1'b0;
                left_r  <= '0;
            end

            // Latch only on the first IDLE cycle of state 9, so a 9 that
            // arrives mid-cell is picked up right after the write.
            if (bus.dtw_state != 4'd9) begin
                fin_seen <= 1'b0;
            end else if (fsm == IDLE && !fin_seen) begin
                dist_r   <= cost_r;
                valid_r  <= 1'b1;
                fin_seen <= 1'b1;
            end

            if (busy_r && bus.cell_start) begin
                err_r <= 1'b1;
            end

            case (fsm)
                IDLE: begin
                    if (bus.cell_start && cell_ok) begin
                        fsm      <= LOAD;
                        busy_r   <= 1'b1;
                        temp_r   <= bus.temp_data[31:0];
                        test_r   <= bus.test_data[31:0];
                        st_r     <= bus.dtw_state;
                        up_r     <= '0;
                        diag_r   <= '0;
                        has_up   <= 1'b0;
                        has_diag <= 1'b0;
                        has_left <= 1'b0;
                        case (bus.dtw_state)
                            4'd3: left_r <= '0;
                            4'd4: has_left <= 1'b1;
                            4'd5: begin
                                left_r <= '0;
                                up_r   <= bus.even_douta;
                                has_up <= 1'b1;
                            end
                            4'd6: begin
                                up_r     <= bus.even_douta;
                                diag_r   <= bus.even_doutb;
                                has_up   <= 1'b1;
                                has_diag <= 1'b1;
                                has_left <= 1'b1;
                            end
                            4'd7: begin
                                left_r <= '0;
                                up_r   <= bus.odd_douta;
                                has_up <= 1'b1;
                            end
                            default: begin
                                up_r     <= bus.odd_douta;
                                diag_r   <= bus.odd_doutb;
                                has_up   <= 1'b1;
                                has_diag <= 1'b1;
                                has_left <= 1'b1;
                            end
                        endcase
                    end
                end
                LOAD: begin
                    d_r <= d_c;
                    fsm <= DIST;
                end
                DIST: begin
                    m_r <= m_c;
                    fsm <= MIN;
                end
                MIN: begin
                    cost_r      <= cost_c;
                    left_r      <= cost_c;
                    cell_done_r <= 1'b1;
                    if (st_r == 4'd5 || st_r == 4'd6) begin
                        odd_we_r <= 1'b1;
                    end else begin
                        even_we_r <= 1'b1;
                    end
                    fsm <= WRITE;
                end
                default: begin
                    busy_r <= 1'b0;
                    fsm    <= IDLE;
                end
            endcase
        end
    end

    assign bus.even_we      = even_we_r;
    assign bus.odd_we       = odd_we_r;
    assign bus.cost_wdata   = cost_r;
    assign bus.busy         = busy_r;
    assign bus.cell_done    = cell_done_r;
    assign bus.err_overrun  = err_r;
    assign bus.dtw_distance = dist_r;
    assign bus.result_valid = valid_r;
endmodule

// File: tb/tb_dtw_cost_engine.sv
// Bench for dtw_cost_engine: directed cells, overrun/final/reset sequences,
// then random DTW matrices checked against a plain DTW recursion.
module tb_dtw_cost_engine;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dtw_cost_engine_if #(.DW(DW)) bus ();
    dtw_cost_engine #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic longint feat_dist(input logic [31:0] a, input logic [31:0] b);
        int x0, x1;
        x0 = int'($signed(a[15:0])) - int'($signed(b[15:0]));
        x1 = int'($signed(a[31:16])) - int'($signed(b[31:16]));
        if (x0 < 0) x0 = -x0;
        if (x1 < 0) x1 = -x1;
        return longint'(x0) + longint'(x1);
    endfunction

    function automatic longint sat32(input longint v);
        return (v > longint'(32'hFFFF_FFFF)) ? longint'(32'hFFFF_FFFF) : v;
    endfunction

    task automatic all_zero(input string tag);
        check({tag, " flags"}, {bus.busy, bus.even_we, bus.odd_we, bus.cell_done,
                               bus.err_overrun, bus.result_valid}, 0);
        check({tag, " cost_wdata"}, bus.cost_wdata, 0);
        check({tag, " dtw_distance"}, bus.dtw_distance, 0);
    endtask

    // Issue one cell at cycle N and check the N+1..N+5 window.
    task automatic run_cell(input string tag, input logic [3:0] st,
                            input logic [31:0] tmp, input logic [31:0] tst,
                            input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] oa, input logic [31:0] ob,
                            input logic [3:0] after_st,
                            input logic [31:0] exp_cost, input bit exp_even);
        logic early;
        logic busy_all;
        @(posedge clk); #1;
        bus.dtw_state  = st;
        bus.cell_start = 1'b1;
        bus.temp_data  = tmp;
        bus.test_data  = tst;
        bus.even_douta = ea;
        bus.even_doutb = eb;
        bus.odd_douta  = oa;
        bus.odd_doutb  = ob;
        @(posedge clk); #1;
        bus.cell_start = 1'b0;
        bus.dtw_state  = after_st;
        bus.temp_data  = $urandom();
        bus.test_data  = $urandom();
        bus.even_douta = $urandom();
        bus.even_doutb = $urandom();
        bus.odd_douta  = $urandom();
        bus.odd_doutb  = $urandom();
        early    = 1'b0;
        busy_all = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            early    = early | bus.even_we | bus.odd_we | bus.cell_done;
            busy_all = busy_all & bus.busy;
        end
        check({tag, " early strobe"}, early, 0);
        check({tag, " busy"}, busy_all, 1);
        @(posedge clk); #1;
        check({tag, " even_we"}, bus.even_we, exp_even);
        check({tag, " odd_we"}, bus.odd_we, !exp_even);
        check({tag, " cell_done"}, bus.cell_done, 1);
        check({tag, " cost"}, bus.cost_wdata, exp_cost);
        @(posedge clk); #1;
        check({tag, " strobes off"}, {bus.even_we, bus.odd_we, bus.cell_done, bus.busy}, 0);
        check({tag, " cost hold"}, bus.cost_wdata, exp_cost);
    endtask

    longint      dm [6][6];
    logic [31:0] tmpl [6];
    logic [31:0] tsmp [6];

    initial begin
        logic [31:0] sat_v;
        int writes;
        bus.dtw_state  = 4'd0;
        bus.cell_start = 1'b0;
        bus.temp_data  = '0;
        bus.test_data  = '0;
        bus.even_douta = '0;
        bus.even_doutb = '0;
        bus.odd_douta  = '0;
        bus.odd_doutb  = '0;
        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");
        rst = 1'b0;
        bus.dtw_state = 4'd1;

        // Directed cells
        run_cell("s3", 4'd3, 32'h0005_0003, 32'h0002_0007, 0, 0, 0, 0, 4'd3, 32'd7, 1);
        run_cell("s4", 4'd4, 32'h0000_000A, 32'h0000_0004, 0, 0, 0, 0, 4'd4, 32'd13, 1);
        run_cell("s5", 4'd5, 32'h0000_000A, 32'h0000_000A, 32'd13, 32'd1, 32'd1, 32'd1, 4'd5, 32'd13, 0);
        run_cell("s5 l20", 4'd5, 32'h1234_5678, 32'h1234_5678, 32'd20, 0, 0, 0, 4'd2, 32'd20, 0);
        run_cell("s6", 4'd6, 32'h0000_0004, 32'h0000_0000, 32'd9, 32'd15, 32'd1, 32'd1, 4'd8, 32'd13, 0);
        run_cell("s7 l50", 4'd7, 32'h0000_0000, 32'h0000_0000, 32'd1, 32'd1, 32'd50, 32'd1, 4'd1, 32'd50, 1);
        run_cell("s8", 4'd8, 32'h0000_FFFF, 32'h0000_0000, 32'd1, 32'd1, 32'd100, 32'd2, 4'd6, 32'd3, 1);
        run_cell("s7 max", 4'd7, 32'h8000_7FFF, 32'h7FFF_8000, 32'd0, 32'd0, 32'd0, 32'd0, 4'd3, 32'd131070, 1);
        sat_v = 32'hFFFF_FFF0;
        run_cell("s5 big", 4'd5, 32'h0, 32'h0, sat_v, 0, 0, 0, 4'd5, sat_v, 0);
        run_cell("sat", 4'd6, 32'h0000_0020, 32'h0, sat_v, sat_v, 0, 0, 4'd6, 32'hFFFF_FFFF, 0);

        // Out-of-range cell_start is ignored silently
        @(posedge clk); #1;
        bus.dtw_state  = 4'd2;
        bus.cell_start = 1'b1;
        @(posedge clk); #1;
        bus.cell_start = 1'b0;
        writes = 0;
        for (int k = 0; k < 5; k++) begin
            writes += int'(bus.even_we | bus.odd_we | bus.cell_done | bus.busy);
            @(posedge clk); #1;
        end
        check("bad state ignored", writes, 0);
        check("bad state no err", bus.err_overrun, 0);

        // Overrun: second pulse at N+2 is dropped and flagged
        bus.dtw_state  = 4'd3;
        bus.temp_data  = 32'h0005_0003;
        bus.test_data  = 32'h0002_0007;
        bus.cell_start = 1'b1;
        @(posedge clk); #1;
        bus.cell_start = 1'b0;
        @(posedge clk); #1;
        bus.dtw_state  = 4'd4;
        bus.temp_data  = 32'h0100_0000;
        bus.cell_start = 1'b1;
        @(posedge clk); #1;
        bus.cell_start = 1'b0;
        check("ovr early", {bus.even_we, bus.odd_we}, 0);
        @(posedge clk); #1;
        check("ovr we", bus.even_we, 1);
        check("ovr cost", bus.cost_wdata, 32'd7);
        check("ovr err", bus.err_overrun, 1);
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            writes += int'(bus.even_we | bus.odd_we);
        end
        check("ovr single write", writes, 0);
        check("final pre valid", bus.result_valid, 0);
        bus.dtw_state = 4'd9;
        @(posedge clk); #1;
        check("final valid", bus.result_valid, 1);
        check("final dist", bus.dtw_distance, 32'd7);
        bus.dtw_state = 4'd0;
        @(posedge clk); #1;
        check("clear valid", bus.result_valid, 0);
        check("clear err", bus.err_overrun, 0);
        bus.dtw_state = 4'd1;
        run_cell("left cleared", 4'd4, 32'h0003_0000, 32'h0, 0, 0, 0, 0, 4'd4, 32'd3, 1);

        // Reset mid-cell
        @(posedge clk); #1;
        bus.dtw_state  = 4'd3;
        bus.cell_start = 1'b1;
        @(posedge clk); #1;
        bus.cell_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        all_zero("rst mid");
        @(posedge clk); #1;
        all_zero("rst N+4");

        // Random DTW matrices against the textbook recursion
        for (int mtx = 0; mtx < 4; mtx++) begin
            int rows, cols;
            logic [3:0] st, after;
            logic [31:0] ea, eb, oa, ob, up, dg;
            rows = $urandom_range(2, 5);
            cols = $urandom_range(2, 5);
            for (int i = 0; i < rows; i++) tmpl[i] = $urandom();
            for (int j = 0; j < cols; j++) tsmp[j] = $urandom();
            for (int i = 0; i < rows; i++) begin
                for (int j = 0; j < cols; j++) begin
                    longint best;
                    best = -1;
                    if (i > 0) best = dm[i-1][j];
                    if (i > 0 && j > 0 && dm[i-1][j-1] < best) best = dm[i-1][j-1];
                    if (j > 0 && (best < 0 || dm[i][j-1] < best)) best = dm[i][j-1];
                    if (best < 0) best = 0;
                    dm[i][j] = sat32(feat_dist(tmpl[i], tsmp[j]) + best);
                end
            end
            for (int i = 0; i < rows; i++) begin
                for (int j = 0; j < cols; j++) begin
                    if (i == 0)          st = (j == 0) ? 4'd3 : 4'd4;
                    else if (i % 2 == 1) st = (j == 0) ? 4'd5 : 4'd6;
                    else                 st = (j == 0) ? 4'd7 : 4'd8;
                    ea = $urandom(); eb = $urandom(); oa = $urandom(); ob = $urandom();
                    if (i > 0) begin
                        up = dm[i-1][j][31:0];
                        dg = (j > 0) ? dm[i-1][j-1][31:0] : $urandom();
                        if ((i - 1) % 2 == 0) begin ea = up; eb = dg; end
                        else                  begin oa = up; ob = dg; end
                    end
                    after = (i == rows - 1 && j == cols - 1) ? 4'd9 : 4'($urandom_range(1, 8));
                    run_cell($sformatf("m%0d c%0d_%0d", mtx, i, j), st, tmpl[i], tsmp[j],
                             ea, eb, oa, ob, after, dm[i][j][31:0], (i % 2 == 0));
                end
            end
            check("rand valid after write", bus.result_valid, 0);
            @(posedge clk); #1;
            check("rand valid", bus.result_valid, 1);
            check("rand dist", bus.dtw_distance, dm[rows-1][cols-1][31:0]);
            bus.dtw_state = 4'd0;
            @(posedge clk); #1;
            check("rand clear", bus.result_valid, 0);
            bus.dtw_state = 4'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
